// File: rtl/pc_stack_pkg.sv
// Shared types and helpers for the v2 program counter and its return-address stack.
package pc_stack_pkg;

  // Control-flow kinds decoded from the instruction; value 7 is unused (never taken).
  typedef enum logic [2:0] {
    JMP  = 3'd0,
    JZ   = 3'd1,
    JNZ  = 3'd2,
    JL   = 3'd3,
    JGE  = 3'd4,
    CALL = 3'd5,
    RET  = 3'd6
  } jump_t;

  // Bits needed to count 0..sd valid RAS entries.
  function automatic int depth_width(input int sd);
    return $clog2(sd + 1);
  endfunction

  // Bits needed to address sd RAS slots (at least one bit).
  function automatic int index_width(input int sd);
    return (sd > 1) ? $clog2(sd) : 1;
  endfunction

endpackage

// File: rtl/pc_stack_if.sv
// Decoder/flag/fetch-side bundle of the program counter.
interface pc_stack_if
  import pc_stack_pkg::*;
#(
  parameter int A_WIDTH     = 8,
  parameter int STACK_DEPTH = 4
);

  localparam int DEPTH_W = depth_width(STACK_DEPTH);

  logic               stall;
  logic               is_jump;
  jump_t              jump_cond;
  logic               is_rel;
  logic               flag_z;
  logic               flag_s;
  logic               flag_o;
  logic [A_WIDTH-1:0] jump_addr;
  logic [A_WIDTH-1:0] addr;
  logic [A_WIDTH-1:0] incremented;
  logic [DEPTH_W-1:0] depth;
  logic               ras_overflow;
  logic               ras_underflow;

  // Decoder / ALU side drives the instruction and flags, observes the PC.
  modport master (
    output stall, is_jump, jump_cond, is_rel, flag_z, flag_s, flag_o, jump_addr,
    input  addr, incremented, depth, ras_overflow, ras_underflow
  );

  // Program counter side.
  modport slave (
    input  stall, is_jump, jump_cond, is_rel, flag_z, flag_s, flag_o, jump_addr,
    output addr, incremented, depth, ras_overflow, ras_underflow
  );

endinterface

// File: rtl/pc_stack_ras.sv
// Hardware return-address stack: register array indexed by the entry count.
module pc_ras
  import pc_stack_pkg::*;
#(
  parameter int A_WIDTH     = 8,
  parameter int STACK_DEPTH = 4
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 i_push,
  input  logic                                 i_pop,
  input  logic [A_WIDTH-1:0]                   i_wdata,
  output logic [A_WIDTH-1:0]                   o_rdata,
  output logic [depth_width(STACK_DEPTH)-1:0]  o_depth,
  output logic                                 o_full,
  output logic                                 o_empty
);

  localparam int DW = depth_width(STACK_DEPTH);
  localparam int IW = index_width(STACK_DEPTH);
  localparam logic [DW-1:0] FULL_CNT = DW'(STACK_DEPTH);

  logic [A_WIDTH-1:0] r_mem [STACK_DEPTH];
  logic [DW-1:0]      r_depth;

  logic [DW-1:0]      w_depth_m1;
  logic [IW-1:0]      w_wr_idx;
  logic [IW-1:0]      w_rd_idx;
  logic               w_do_push;
  logic               w_do_pop;

  // Index and guard decode; an empty stack reads slot 0 so the index never leaves the array.
  always_comb begin
    o_full     = (r_depth == FULL_CNT);
    o_empty    = (r_depth == '0);
    w_do_push  = i_push && !o_full;
    w_do_pop   = i_pop && !o_empty;
    w_depth_m1 = r_depth - DW'(1);
    w_wr_idx   = r_depth[IW-1:0];
    w_rd_idx   = o_empty ? '0 : w_depth_m1[IW-1:0];
  end

  // Entry count; the only stack state that needs reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_depth <= '0;
    end else if (w_do_push) begin
      r_depth <= r_depth + DW'(1);
    end else if (w_do_pop) begin
      r_depth <= w_depth_m1;
    end
  end

  // Storage array; contents are meaningless beyond the current depth, so no reset.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[w_wr_idx] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[w_rd_idx];
  assign o_depth = r_depth;

endmodule

// File: rtl/pc_stack.sv
// Program counter with conditional/relative jumps, fetch stall and CALL/RET via a RAS.
module pc_stack
  import pc_stack_pkg::*;
#(
  parameter int A_WIDTH     = 8,
  parameter int STACK_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  pc_stack_if.slave   bus
);

  localparam int DW = depth_width(STACK_DEPTH);

  logic [A_WIDTH-1:0] r_addr;
  logic               r_ovf;
  logic               r_unf;

  logic [A_WIDTH-1:0] w_inc;
  logic [A_WIDTH-1:0] w_target;
  logic [A_WIDTH-1:0] w_next;
  logic               w_push_req;
  logic               w_pop_req;
  logic               w_set_ovf;
  logic               w_set_unf;
  logic [A_WIDTH-1:0] w_ras_rdata;
  logic [DW-1:0]      w_ras_depth;
  logic               w_ras_full;
  logic               w_ras_empty;

  // Fall-through address and jump target, both modulo 2^A_WIDTH.
  always_comb begin
    w_inc    = r_addr + A_WIDTH'(1);
    w_target = bus.is_rel ? (r_addr + bus.jump_addr) : bus.jump_addr;
  end

  // Next-PC selection, condition evaluation and RAS requests for this instruction.
  always_comb begin
    w_next     = w_inc;
    w_push_req = 1'b0;
    w_pop_req  = 1'b0;
    w_set_ovf  = 1'b0;
    w_set_unf  = 1'b0;
    if (bus.is_jump) begin
      case (bus.jump_cond)
        JMP:  w_next = w_target;
        JZ:   if (bus.flag_z)                   w_next = w_target;
        JNZ:  if (!bus.flag_z)                  w_next = w_target;
        JL:   if (bus.flag_s ^ bus.flag_o)      w_next = w_target;
        JGE:  if (!(bus.flag_s ^ bus.flag_o))   w_next = w_target;
        CALL: begin
          w_next = w_target;
          if (w_ras_full) w_set_ovf  = 1'b1;
          else            w_push_req = 1'b1;
        end
        RET: begin
          if (w_ras_empty) begin
            w_set_unf = 1'b1;
          end else begin
            w_next    = w_ras_rdata;
            w_pop_req = 1'b1;
          end
        end
        default: w_next = w_inc;
      endcase
    end
  end

  // PC and sticky error flags; a stalled cycle changes nothing.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr <= '0;
      r_ovf  <= 1'b0;
      r_unf  <= 1'b0;
    end else if (!bus.stall) begin
      r_addr <= w_next;
      r_ovf  <= r_ovf | w_set_ovf;
      r_unf  <= r_unf | w_set_unf;
    end
  end

  pc_ras #(
    .A_WIDTH     (A_WIDTH),
    .STACK_DEPTH (STACK_DEPTH)
  ) u_ras (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push_req && !bus.stall),
    .i_pop   (w_pop_req && !bus.stall),
    .i_wdata (w_inc),
    .o_rdata (w_ras_rdata),
    .o_depth (w_ras_depth),
    .o_full  (w_ras_full),
    .o_empty (w_ras_empty)
  );

  assign bus.addr          = r_addr;
  assign bus.incremented   = w_inc;
  assign bus.depth         = w_ras_depth;
  assign bus.ras_overflow  = r_ovf;
  assign bus.ras_underflow = r_unf;

endmodule

// File: doc/pc_stack.md
Name: pc_stack

Overview:
Parametrised program counter for the v2 core. Adds to plain/conditional jumps: PC-relative targets, a fetch stall, and CALL/RET through a hardware return-address stack (RAS) of configurable depth. Sits between the decoder (jump kind, target/offset) and instruction memory (addr). Flags come from the ALU flag register.

Parameters:
A_WIDTH, 8, instruction address width in bits; PC arithmetic is modulo 2^A_WIDTH.
STACK_DEPTH, 4, number of RAS entries; must be >= 1. Not required to be a power of two.

Ports:
clk  input  1  clock.
rst  input  1  reset: asynchronous, active-high.
stall  input  1  freezes the PC, RAS and sticky flags for this cycle.
is_jump  input  1  current instruction is a control-flow instruction.
jump_cond  input  jump_t (3)  JMP, JZ, JNZ, JL, JGE, CALL, RET.
is_rel  input  1  target = addr + jump_addr (two's complement, modulo 2^A_WIDTH); else target = jump_addr.
flag_z  input  1  zero flag.
flag_s  input  1  sign flag.
flag_o  input  1  overflow flag.
jump_addr  input  A_WIDTH  absolute target, or signed offset when is_rel.
addr  output  A_WIDTH  current PC (registered).
incremented  output  A_WIDTH  addr + 1, modulo 2^A_WIDTH (combinational).
depth  output  $clog2(STACK_DEPTH+1)  number of valid RAS entries (registered).
ras_overflow  output  1  sticky: CALL issued with RAS full.
ras_underflow  output  1  sticky: RET issued with RAS empty.

Behaviour:
- Reset (async, any time, including mid-CALL): addr=0, depth=0, ras_overflow=0, ras_underflow=0. RAS contents are don't-care.
- All state updates occur on posedge clk when rst=0 and stall=0. With stall=1, every register holds and no push or pop occurs.
- Jump not taken (is_jump=0, or the condition is false): addr <= incremented.
- JMP: addr <= target.
- JZ: taken if flag_z.
- JNZ: taken if !flag_z.
- JL: taken if flag_s ^ flag_o (signed less-than).
- JGE: taken if !(flag_s ^ flag_o).
- Unlisted encodings: treated as not taken.
- is_rel applies to JMP, JZ, JNZ, JL, JGE and CALL; it is ignored for RET. The offset is relative to the current addr, not to incremented.
- CALL, depth < STACK_DEPTH: push incremented; depth+1; addr <= target.
- CALL, depth == STACK_DEPTH: addr <= target; no push; depth unchanged; ras_overflow <= 1.
- RET, depth > 0: addr <= top entry; depth-1.
- RET, depth == 0: addr <= incremented; ras_underflow <= 1; depth stays 0.
- Latency: the new addr is visible one cycle after the instruction is presented. There are no delay slots.
- Wrap-around: incremented of 2^A_WIDTH-1 is 0. Relative targets wrap the same way.
- Sticky flags clear only on rst.
- Mid-sequence stall: a CALL or RET held under stall is executed exactly once, in the first cycle with stall=0.

Decomposition:
- Shared package (enums.svh): extend jump_t to 3 bits: JMP=0, JZ=1, JNZ=2, JL=3, JGE=4, CALL=5, RET=6.
- Sub-module pc_ras (parameters A_WIDTH, STACK_DEPTH):
  - Inputs: push, pop, wdata.
  - Outputs: rdata (top entry), depth, full, empty.
  - Register array indexed by depth; push when full and pop when empty are ignored internally.
- pc_stack owns condition evaluation, target computation, the sticky flags and the addr register.

Test Plan:
- Reset then 3 cycles with is_jump=0 -> addr 0,1,2,3. With A_WIDTH=8, starting from 0xFF -> addr 0x00.
- JL with (s,o)=(1,1) -> not taken, addr+1. With (0,1) -> taken to jump_addr. JGE with (1,1) -> taken.
- Relative: addr=0x10, is_rel=1, JMP, jump_addr=0xFE -> addr=0x0E. addr=0xFF, jump_addr=0x02 -> addr=0x01.
- Nested calls: CALL 0x40 at 0x05, CALL 0x80 at 0x41, RET, RET -> addr 0x40, 0x80, 0x42, 0x06; depth 1,2,1,0.
- STACK_DEPTH=4: five CALLs -> fifth jumps, depth stays 4, ras_overflow=1. Then five RETs -> four return in LIFO order, fifth gives incremented with ras_underflow=1.
- stall=1 for 3 cycles during a CALL -> addr and depth frozen, single push after release. Assert rst mid-stall -> addr=0, depth=0, flags 0 immediately (async).
